snow64_instr_fetch: RTL and testbench

//  Instruction fetch stage; sits directly upstream of Snow64InstrCache and

---
 rtl/snow64_instr_fetch_pkg.sv | 43 ++++
 rtl/snow64_fetch_queue.sv | 82 ++++++++
 rtl/snow64_instr_fetch.sv | 129 ++++++++++++
 tb/tb_snow64_instr_fetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/snow64_instr_fetch_pkg.sv
// Shared types for the Snow64 instruction fetch stage.
//  - state_e          : fetch FSM states
//  - queue_entry_t    : one buffered instruction and the PC it was fetched from
//  - port_in_t        : decoder -> fetch handshake
//  - port_out_t       : fetch -> decoder payload
//  - icache_req_read_t: read request toward the instruction cache
package snow64_instr_fetch_pkg;

    localparam int unsigned ADDR_WIDTH  = 64;
    localparam int unsigned INSTR_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } queue_entry_t;

    typedef struct packed {
        logic ready;
    } port_in_t;

    typedef struct packed {
        logic                   valid;
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } port_out_t;

    typedef struct packed {
        logic                  req;
        logic [ADDR_WIDTH-1:0] addr;
    } icache_req_read_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/snow64_fetch_queue.sv
// Synchronous FIFO of fetched instructions.
//  clk, rst_n     : clock, synchronous active-low reset
//  flush          : empty the queue (wins over push/pop)
//  push/push_entry: write one entry (accepted when not full, or full with pop)
//  pop            : consume head (ignored when empty)
//  head_entry     : head entry read combinationally from registered storage
//  count          : number of valid entries
module snow64_fetch_queue
    import snow64_instr_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  queue_entry_t     push_entry,
    input  logic             pop,
    output queue_entry_t     head_entry,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    queue_entry_t     mem_q [DEPTH];
    queue_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer/count update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule

// File: rtl/snow64_instr_fetch.sv
// Instruction fetch stage: holds the PC, issues one icache read at a time and
// buffers returned instructions with their PCs for the decoder. A redirect
// flushes the buffer and drops any response still in flight.
//  clk, rst_n                  : clock, synchronous active-low reset
//  redirect_valid, redirect_pc : one-cycle branch redirect, new PC (bits [1:0] ignored)
//  icache_req, icache_addr     : registered read request (one-cycle pulse)
//  icache_valid, icache_instr  : icache response strobe and data
//  out_valid/out_instr/out_pc  : FIFO head toward decoder
//  out_ready                   : decoder accepts head
module snow64_instr_fetch
    import snow64_instr_fetch_pkg::*;
#(
    parameter int unsigned           QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   icache_req,
    output logic [ADDR_WIDTH-1:0]  icache_addr,
    input  logic                   icache_valid,
    input  logic [INSTR_WIDTH-1:0] icache_instr,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    input  logic                   out_ready
);

    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    icache_req_read_t      rd_req_q, rd_req_d;

    logic                  fifo_flush;
    logic                  fifo_push;
    logic                  fifo_pop;
    queue_entry_t          fifo_push_entry;
    queue_entry_t          fifo_head;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    port_in_t              dec_in;
    port_out_t             dec_out;

    assign dec_in.ready      = out_ready;
    assign fifo_full         = (fifo_count == CNT_W'(QUEUE_DEPTH));
    assign fifo_pop          = dec_out.valid && dec_in.ready;
    assign fifo_push_entry   = '{pc: pc_q, instr: icache_instr};

    // Next state, PC and request; redirect handling overrides the per-state result.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rd_req_d.req  = 1'b0;
        rd_req_d.addr = rd_req_q.addr;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_full && !redirect_valid) begin
                    state_d       = ST_WAIT;
                    rd_req_d.req  = 1'b1;
                    rd_req_d.addr = pc_q;
                end
            end
            ST_WAIT: begin
                if (icache_valid) begin
                    fifo_push = 1'b1;
                    pc_d      = pc_q + ADDR_WIDTH'(4);
                    state_d   = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (icache_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            fifo_flush = 1'b1;
            fifo_push  = 1'b0;
            pc_d       = align_pc(redirect_pc);
            // Response still outstanding: it belongs to the old path.
            if (state_q == ST_WAIT && !icache_valid) begin
                state_d = ST_DISCARD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            rd_req_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_req_q <= rd_req_d;
        end
    end

    snow64_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_entry (fifo_push_entry),
        .pop        (fifo_pop),
        .head_entry (fifo_head),
        .count      (fifo_count)
    );

    assign dec_out.valid = (fifo_count != '0);
    assign dec_out.instr = fifo_head.instr;
    assign dec_out.pc    = fifo_head.pc;

    assign icache_req  = rd_req_q.req;
    assign icache_addr = rd_req_q.addr;
    assign out_valid   = dec_out.valid;
    assign out_instr   = dec_out.instr;
    assign out_pc      = dec_out.pc;

endmodule

// File: tb/tb_snow64_instr_fetch.sv
module tb_snow64_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        icache_req;
    logic [63:0] icache_addr;
    logic        icache_valid;
    logic [31:0] icache_instr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;

    int n_vec  = 0;
    int n_miss = 0;

    snow64_instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .icache_req     (icache_req),
        .icache_addr    (icache_addr),
        .icache_valid   (icache_valid),
        .icache_instr   (icache_instr),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_req", 64'(icache_req), 64'd0);
        chk("rst_addr", icache_addr, 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
    endtask

    // Advance to the cycle where a request is visible (bounded) and check its address.
    task automatic wait_req(input logic [63:0] exp_addr);
        int n = 0;
        while (!icache_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 64'(icache_req), 64'd1);
        chk("req_addr", icache_addr, exp_addr);
    endtask

    // Answer one request one cycle after it appears; ends in the cycle the entry is visible.
    task automatic serve(input logic [31:0] instr, input logic [63:0] exp_addr);
        wait_req(exp_addr);
        tick();
        icache_valid = 1'b1;
        icache_instr = instr;
        tick();
        icache_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        icache_valid   = 1'b0;
        icache_instr   = '0;
        out_ready      = 1'b0;

        // Reset, then the first request appears one cycle after release.
        do_reset();
        tick();
        chk("t1_req", 64'(icache_req), 64'd1);
        chk("t1_addr", icache_addr, 64'd0);

        // Streaming with decoder always ready.
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            serve(32'h1000_0000 + 32'(k), 64'(4 * k));
            chk("t2_valid", 64'(out_valid), 64'd1);
            chk("t2_pc", out_pc, 64'(4 * k));
            chk("t2_instr", 64'(out_instr), 64'(32'h1000_0000 + 32'(k)));
        end

        // Back-pressure: fill the queue, no request while full, one pop frees a slot.
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve(32'h2000_0000 + 32'(k), 64'(4 * k));
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t3_full_noreq", 64'(icache_req), 64'd0);
        end
        chk("t3_head_pc", out_pc, 64'h0);
        chk("t3_head_instr", 64'(out_instr), 64'h2000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_pop_head", out_pc, 64'h4);
        wait_req(64'h10);
        tick();
        icache_valid = 1'b1;
        icache_instr = 32'h2000_0004;
        tick();
        icache_valid = 1'b0;
        out_ready    = 1'b1;
        for (int k = 1; k < 5; k++) begin
            chk("t3_drain_pc", out_pc, 64'(4 * k));
            chk("t3_drain_instr", 64'(out_instr), 64'(32'h2000_0000 + 32'(k)));
            tick();
        end

        // Redirect while waiting; late response is discarded.
        do_reset();
        out_ready = 1'b1;
        wait_req(64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2000;
        tick();
        redirect_valid = 1'b0;
        chk("t4_discard_noreq", 64'(icache_req), 64'd0);
        chk("t4_empty", 64'(out_valid), 64'd0);
        tick();
        tick();
        chk("t4_still_noreq", 64'(icache_req), 64'd0);
        icache_valid = 1'b1;
        icache_instr = 32'hDEAD_BEEF;
        tick();
        icache_valid = 1'b0;
        chk("t4_dropped", 64'(out_valid), 64'd0);
        serve(32'h3000_0000, 64'h2000);
        chk("t4_valid", 64'(out_valid), 64'd1);
        chk("t4_pc", out_pc, 64'h2000);
        chk("t4_instr", 64'(out_instr), 64'h3000_0000);

        // Redirect in IDLE: new request two cycles later, queue flushed.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h4000;
        tick();
        redirect_valid = 1'b0;
        chk("lat_noreq", 64'(icache_req), 64'd0);
        chk("lat_flushed", 64'(out_valid), 64'd0);
        tick();
        chk("lat_req", 64'(icache_req), 64'd1);
        chk("lat_addr", icache_addr, 64'h4000);

        // Redirect coincident with response: dropped, no discard state.
        tick();
        icache_valid   = 1'b1;
        icache_instr   = 32'h0000_0BAD;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        tick();
        icache_valid   = 1'b0;
        redirect_valid = 1'b0;
        chk("t5_noreq", 64'(icache_req), 64'd0);
        chk("t5_dropped", 64'(out_valid), 64'd0);
        tick();
        chk("t5_req", 64'(icache_req), 64'd1);
        chk("t5_addr", icache_addr, 64'h2000);
        serve(32'h5000_0000, 64'h2000);
        chk("t5_pc", out_pc, 64'h2000);
        chk("t5_instr", 64'(out_instr), 64'h5000_0000);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        serve(32'h6000_0000, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        serve(32'h6000_0001, 64'h0);
        chk("t6_pc_wrap", out_pc, 64'h0);
        chk("t6_instr", 64'(out_instr), 64'h6000_0001);

        // Reset mid-wait with a stray response during reset.
        wait_req(64'h4);
        rst_n        = 1'b0;
        icache_valid = 1'b1;
        icache_instr = 32'h0BAD_0BAD;
        tick();
        icache_valid = 1'b0;
        tick();
        chk("t7_rst_req", 64'(icache_req), 64'd0);
        chk("t7_rst_empty", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("t7_req", 64'(icache_req), 64'd1);
        chk("t7_addr", icache_addr, 64'h0);
        chk("t7_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
